// File: rtl/egg_countdown.sv
// egg_countdown: MM:SS BCD digit datapath for an egg timer.
// Set mode increments seconds or minutes on each press of inc.
// Starting mode counts down once per tick and stops at 00:00.
// Flashing mode can blink the display.
// Optional feature: define EGG_COUNTDOWN_BLINK_EN to make blank toggle on each
// tick while flashing. When it is undefined, blank is tied low and no blink
// register exists.
module egg_countdown #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       isInit,
  input  logic       isSecond,
  input  logic       isMinute,
  input  logic       isStarting,
  input  logic       isStopping,
  input  logic       isFlashing,
  input  logic       inc,
  input  logic       tick,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       isZero,
  output logic       blank
);

  // The highest settable minute value, split into its two BCD digits.
  localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

  // The effective mode after the flag priority has been resolved.
  typedef enum logic [2:0] {
    MODE_HOLD,
    MODE_INIT,
    MODE_SEC,
    MODE_MIN,
    MODE_START,
    MODE_FLASH
  } mode_t;

  mode_t      mode;
  logic       inc_q;
  logic       inc_rise;
  logic [3:0] min_tens_d;
  logic [3:0] min_ones_d;
  logic [3:0] sec_tens_d;
  logic [3:0] sec_ones_d;

  // Count one press per rising edge of inc, so a button held down across a mode
  // change does not count.
  assign inc_rise = inc & ~inc_q;

  // isZero comes straight from the digit registers and has no added latency.
  assign isZero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd0);

  // Resolve the flags: init > second > minute > starting > flashing.
  // Stopping, or no flag at all, holds the digits.
  always_comb begin
    mode = MODE_HOLD;
    if (isInit)          mode = MODE_INIT;
    else if (isSecond)   mode = MODE_SEC;
    else if (isMinute)   mode = MODE_MIN;
    else if (isStarting) mode = MODE_START;
    else if (isFlashing) mode = MODE_FLASH;
    else if (isStopping) mode = MODE_HOLD;
  end

  // Compute the next digit values for the current mode.
  always_comb begin
    // NOTE: each next-state value gets a default first, so no path can infer a latch.
    min_tens_d = min_tens;
    min_ones_d = min_ones;
    sec_tens_d = sec_tens;
    sec_ones_d = sec_ones;
    case (mode)
      MODE_INIT: begin
        min_tens_d = 4'd0;
        min_ones_d = 4'd0;
        sec_tens_d = 4'd0;
        sec_ones_d = 4'd0;
      end
      MODE_SEC: begin
        // Seconds wrap from 59 to 00. There is no carry into the minutes.
        if (inc_rise) begin
          if (sec_ones == 4'd9) begin
            sec_ones_d = 4'd0;
            sec_tens_d = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
          end else begin
            sec_ones_d = sec_ones + 4'd1;
          end
        end
      end
      MODE_MIN: begin
        // Minutes wrap from MAX_MIN to 00. The seconds do not change.
        if (inc_rise) begin
          if ((min_tens == MAX_TENS) && (min_ones == MAX_ONES)) begin
            min_tens_d = 4'd0;
            min_ones_d = 4'd0;
          end else if (min_ones == 4'd9) begin
            min_ones_d = 4'd0;
            min_tens_d = min_tens + 4'd1;
          end else begin
            min_ones_d = min_ones + 4'd1;
          end
        end
      end
      MODE_START: begin
        // Subtract one second, borrowing through the BCD digits.
        // The count stays at 00:00 once it gets there.
        if (tick && !isZero) begin
          if (sec_ones != 4'd0) begin
            sec_ones_d = sec_ones - 4'd1;
          end else begin
            sec_ones_d = 4'd9;
            if (sec_tens != 4'd0) begin
              sec_tens_d = sec_tens - 4'd1;
            end else begin
              sec_tens_d = 4'd5;
              if (min_ones != 4'd0) begin
                min_ones_d = min_ones - 4'd1;
              end else begin
                min_ones_d = 4'd9;
                min_tens_d = min_tens - 4'd1;
              end
            end
          end
        end
      end
      default: begin
        // Hold and flashing leave the digits unchanged.
      end
    endcase
  end

  // Digit and press-edge registers.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous and clears every state bit. There is no memory array, so nothing is left unreset.
    if (reset) begin
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      inc_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values from before the edge.
      min_tens <= min_tens_d;
      min_ones <= min_ones_d;
      sec_tens <= sec_tens_d;
      sec_ones <= sec_ones_d;
      inc_q    <= inc;
    end
  end

`ifdef EGG_COUNTDOWN_BLINK_EN
  logic blank_q;

  // Toggle blank on each tick while flashing. Clear it in every other mode,
  // so each flashing period starts with the display visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q <= 1'b0;
    end else if (mode != MODE_FLASH) begin
      blank_q <= 1'b0;
    end else if (tick) begin
      blank_q <= ~blank_q;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_egg_countdown.sv
// tb_egg_countdown: bench for egg_countdown.
// A reference model keeps minutes and seconds as plain integers. A compare
// process checks every output on every cycle. Directed sequences pin known
// values, and a randomized phase follows them.
module tb_egg_countdown;

  localparam int MAX_MIN = 59;

  // Flag vector bit order: {init, second, minute, starting, stopping, flashing}.
  localparam logic [5:0] F_NONE  = 6'b000000;
  localparam logic [5:0] F_INIT  = 6'b100000;
  localparam logic [5:0] F_SEC   = 6'b010000;
  localparam logic [5:0] F_MIN   = 6'b001000;
  localparam logic [5:0] F_START = 6'b000100;
  localparam logic [5:0] F_STOP  = 6'b000010;
  localparam logic [5:0] F_FLASH = 6'b000001;

`ifdef EGG_COUNTDOWN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] flags = F_NONE;
  logic       inc   = 1'b0;
  logic       tick  = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       isZero, blank;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  egg_countdown #(.MAX_MIN(MAX_MIN)) dut (
    .clk        (clk),
    .reset      (reset),
    .isInit     (flags[5]),
    .isSecond   (flags[4]),
    .isMinute   (flags[3]),
    .isStarting (flags[2]),
    .isStopping (flags[1]),
    .isFlashing (flags[0]),
    .inc        (inc),
    .tick       (tick),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .isZero     (isZero),
    .blank      (blank)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. It holds the time as two integers and the previous inc level.
  int m_sec = 0;
  int m_min = 0;
  bit m_inc_q = 1'b0;
  bit m_blank = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int s, m, t;
    bit flashing;
    s = m_sec;
    m = m_min;
    flashing = 1'b0;
    if (reset) begin
      s = 0;
      m = 0;
    end else if (flags[5]) begin
      s = 0;
      m = 0;
    end else if (flags[4]) begin
      if (inc && !m_inc_q) s = (s + 1) % 60;
    end else if (flags[3]) begin
      if (inc && !m_inc_q) m = (m + 1) % (MAX_MIN + 1);
    end else if (flags[2]) begin
      if (tick) begin
        t = m * 60 + s;
        if (t > 0) t = t - 1;
        m = t / 60;
        s = t % 60;
      end
    end else if (flags[0]) begin
      flashing = 1'b1;
    end
    m_blank <= (BLINK && flashing) ? (m_blank ^ tick) : 1'b0;
    m_inc_q <= reset ? 1'b0 : inc;
    m_sec   <= s;
    m_min   <= m;
    if (reset) m_valid <= 1'b1;
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle", {14'd0, min_tens, min_ones, sec_tens, sec_ones, isZero, blank},
            {14'd0, 4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
             (m_min == 0) && (m_sec == 0), m_blank});
    end
  end

  // Apply one cycle of inputs and return just after the rising edge that uses them.
  task automatic cyc(input logic r, input logic [5:0] f, input logic i, input logic t);
    @(negedge clk);
    reset = r;
    flags = f;
    inc   = i;
    tick  = t;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [5:0] f);
    cyc(1'b0, f, 1'b1, 1'b0);
    cyc(1'b0, f, 1'b0, 1'b0);
  endtask

  task automatic tk(input logic [5:0] f);
    cyc(1'b0, f, 1'b0, 1'b1);
  endtask

  task automatic expect_time(input string name, input logic [15:0] bcd);
    check(name, {16'd0, min_tens, min_ones, sec_tens, sec_ones}, {16'd0, bcd});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    logic [5:0] mode_f;
    pat = BLINK ? 4'b0101 : 4'b0000;

    // Reset state.
    cyc(1'b1, F_NONE, 1'b0, 1'b0);
    cyc(1'b1, F_START, 1'b1, 1'b1);
    expect_time("rst_digits", 16'h0000);
    check("rst_zero", {31'd0, isZero}, 32'd1);
    check("rst_blank", {31'd0, blank}, 32'd0);

    // Set seconds with 61 presses.
    cyc(1'b0, F_SEC, 1'b0, 1'b0);
    for (int i = 1; i <= 61; i++) begin
      press(F_SEC);
      if (i == 1) begin
        expect_time("sec_first", 16'h0001);
        check("sec_first_zero", {31'd0, isZero}, 32'd0);
      end
      if (i == 59) expect_time("sec_59", 16'h0059);
      if (i == 60) expect_time("sec_wrap", 16'h0000);
      if (i == 61) expect_time("sec_61", 16'h0001);
    end

    // Set minutes with 60 presses, then hold inc across a mode change.
    cyc(1'b0, F_INIT, 1'b0, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      press(F_MIN);
      if (i == 1)  expect_time("min_first", 16'h0100);
      if (i == 59) expect_time("min_59", 16'h5900);
      if (i == 60) expect_time("min_wrap", 16'h0000);
    end
    cyc(1'b0, F_STOP, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, F_MIN, 1'b1, 1'b0);
    expect_time("min_held", 16'h0000);
    cyc(1'b0, F_MIN, 1'b0, 1'b0);
    cyc(1'b0, F_MIN, 1'b1, 1'b0);
    expect_time("min_repress", 16'h0100);
    cyc(1'b0, F_STOP, 1'b1, 1'b0);
    cyc(1'b0, F_SEC, 1'b1, 1'b0);
    cyc(1'b0, F_SEC, 1'b1, 1'b0);
    expect_time("sec_held", 16'h0100);

    // Count down from 01:00 to 00:00, then tick once more.
    cyc(1'b0, F_INIT, 1'b0, 1'b0);
    press(F_MIN);
    expect_time("load_0100", 16'h0100);
    tk(F_START);
    expect_time("down_0059", 16'h0059);
    cyc(1'b0, F_START, 1'b1, 1'b0);
    expect_time("start_inc_ignored", 16'h0059);
    for (int i = 0; i < 58; i++) tk(F_START);
    expect_time("down_0001", 16'h0001);
    tk(F_START);
    expect_time("down_0000", 16'h0000);
    check("down_zero", {31'd0, isZero}, 32'd1);
    tk(F_START);
    expect_time("no_underflow", 16'h0000);

    // Load 02:30. Start, stop, then resume.
    cyc(1'b0, F_INIT, 1'b0, 1'b0);
    press(F_MIN);
    press(F_MIN);
    for (int i = 0; i < 30; i++) press(F_SEC);
    expect_time("load_0230", 16'h0230);
    tk(F_SEC);
    tk(F_MIN);
    expect_time("set_tick_ignored", 16'h0230);
    for (int i = 0; i < 5; i++) tk(F_START);
    for (int i = 0; i < 10; i++) cyc(1'b0, F_STOP, 1'(i % 2), 1'b1);
    expect_time("stop_0225", 16'h0225);
    tk(F_START);
    expect_time("resume_0224", 16'h0224);
    cyc(1'b0, F_SEC | F_START, 1'b0, 1'b1);
    expect_time("prio_sec_over_start", 16'h0224);
    cyc(1'b0, F_START | F_FLASH, 1'b0, 1'b1);
    expect_time("prio_start_over_flash", 16'h0223);
    cyc(1'b0, F_INIT | F_SEC, 1'b1, 1'b0);
    expect_time("prio_init", 16'h0000);

    // Flashing at 00:00.
    cyc(1'b0, F_FLASH, 1'b0, 1'b0);
    check("flash_entry_blank", {31'd0, blank}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tk(F_FLASH);
      check($sformatf("flash_blank_%0d", k), {31'd0, blank}, {31'd0, pat[k]});
    end
    expect_time("flash_hold", 16'h0000);
    tk(F_FLASH);
    cyc(1'b0, F_STOP, 1'b0, 1'b0);
    check("flash_exit_blank", {31'd0, blank}, 32'd0);

    // Reset mid-countdown at 03:17, coincident with tick.
    cyc(1'b0, F_INIT, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) press(F_MIN);
    for (int i = 0; i < 17; i++) press(F_SEC);
    cyc(1'b0, F_START, 1'b0, 1'b0);
    expect_time("load_0317", 16'h0317);
    cyc(1'b1, F_START, 1'b1, 1'b1);
    expect_time("reset_mid", 16'h0000);
    check("reset_mid_zero", {31'd0, isZero}, 32'd1);
    check("reset_mid_blank", {31'd0, blank}, 32'd0);
    tk(F_FLASH);
    cyc(1'b1, F_FLASH, 1'b0, 1'b1);
    check("reset_flash_blank", {31'd0, blank}, 32'd0);

    // Randomized phase. Modes are held for random stretches, and a few
    // cycles use multi-hot flags.
    mode_f = F_NONE;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 7))
          0: mode_f = F_NONE;
          1: mode_f = ($urandom_range(0, 3) == 0) ? F_INIT : F_STOP;
          2: mode_f = F_SEC;
          3: mode_f = F_MIN;
          4: mode_f = F_START;
          5: mode_f = F_STOP;
          6: mode_f = F_FLASH;
          default: mode_f = 6'($urandom_range(0, 63));
        endcase
      end
      cyc(($urandom_range(0, 299) == 0), mode_f, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
